// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed driver for four common-anode 7-segment digits.
// Each digit shows one 4-bit counter stage in hex. The counts are snapshotted once per
// refresh frame so a digit never shows a torn value. A rising carry flag on a stage lights
// that digit's decimal point for HOLD frames.
//
// Parameters:
//   DIV       clock cycles per digit slot (2..2^20)
//   HOLD      frames a decimal point stays lit after a carry rising edge (1..15)
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   din       four packed nibbles, digit 0 in din[3:0]
//   cout_in   carry/borrow flag per stage, bit i for digit i
//   blank_lz  1 = blank leading zeros (digit 0 is never blanked)
//   an        anode enables, active-low, one-hot-low while scanning
//   seg       segments {g,f,e,d,c,b,a}, active-low
//   dp        decimal point, active-low
module seg7_scan_display #(
  parameter int unsigned DIV  = 50000,
  parameter int unsigned HOLD = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic [3:0]  cout_in,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned PW = $clog2(DIV);
  localparam logic [PW-1:0] PreMax = PW'(DIV - 1);
  localparam logic [3:0]    HoldInit = 4'(HOLD);

  logic [PW-1:0]   pre_q, pre_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     snap_q, snap_d;
  logic [3:0]      cout_q;
  logic [3:0][3:0] hold_q, hold_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic       tick;
  logic       frame_start;
  logic [3:0] rise;
  logic [3:0] nib;
  logic [3:0] zero_from;  // zero_from[i]: nibbles i..3 of the snapshot are all zero
  logic       blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    tick        = (pre_q == PreMax);
    frame_start = tick && (idx_q == 2'd3);
    pre_d       = tick ? '0 : pre_q + 1'b1;
    idx_d       = tick ? idx_q + 2'd1 : idx_q;
    snap_d      = frame_start ? din : snap_q;
    rise        = cout_in & ~cout_q;

    // A fresh carry reload beats the per-frame decrement.
    hold_d = hold_q;
    for (int i = 0; i < 4; i++) begin
      if (rise[i]) begin
        hold_d[i] = HoldInit;
      end else if (frame_start && (hold_q[i] != 4'd0)) begin
        hold_d[i] = hold_q[i] - 4'd1;
      end
    end

    zero_from    = '0;
    zero_from[3] = (snap_q[15:12] == 4'd0);
    zero_from[2] = zero_from[3] && (snap_q[11:8] == 4'd0);
    zero_from[1] = zero_from[2] && (snap_q[7:4] == 4'd0);
    zero_from[0] = 1'b0;

    nib   = snap_q[{idx_q, 2'b00} +: 4];
    blank = blank_lz && zero_from[idx_q];
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'h7F : hex7(nib);
    dp_d  = ~(hold_q[idx_q] != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      cout_q <= '0;
      hold_q <= '0;
      an_q   <= 4'b1111;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      cout_q <= cout_in;
      hold_q <= hold_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Bench for seg7_scan_display with DIV = 4, HOLD = 3.
// Edge k counts rising edges since reset release (first edge = 0). After edge k the
// outputs show digit (k/DIV)%4; frame starts are edges with k%16 == 15.
module tb_seg7_scan_display;
  localparam int unsigned DIV  = 4;
  localparam int unsigned HOLD = 3;
  localparam int          FL   = 4 * DIV;
  localparam logic [27:0] ZERO = {4{7'b1000000}};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [3:0]  cout_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  seg7_scan_display #(.DIV(DIV), .HOLD(HOLD)) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .cout_in  (cout_in),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  typedef struct {
    int         k;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  typedef struct {
    logic [15:0] din;
    logic        blz;
    logic [27:0] segs;  // {digit3, digit2, digit1, digit0}
  } vec_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   k        = -1;
  int   lit_lo[4];
  int   lit_hi[4];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h want=%h", name, k, got, want);
    end
  endtask

  // Expected outputs for edges first..last, given the digits on show and the dp windows.
  function automatic void push_range(input int first, input int last, input logic [27:0] segs);
    exp_t       e;
    int         d;
    logic [3:0] one;
    one = 4'b0001;
    for (int x = first; x <= last; x++) begin
      d     = (x / int'(DIV)) % 4;
      e.k   = x;
      e.an  = ~(one << d);
      e.seg = segs[7*d +: 7];
      e.dp  = !((lit_lo[d] < x) && (x <= lit_hi[d]));
      sbq.push_back(e);
    end
  endfunction

  function automatic int next_frame(input int x);
    int p;
    p = (x + 1) % FL;
    return x + 1 + (FL - 1 - p);
  endfunction

  function automatic void clear_windows();
    for (int i = 0; i < 4; i++) begin
      lit_lo[i] = -1;
      lit_hi[i] = -1;
    end
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    k++;
    while (sbq.size() > 0 && sbq[0].k <= k) begin
      e = sbq.pop_front();
      if (e.k < k) begin
        checks++;
        failures++;
        $display("FAIL missed_edge got=%0d want=%0d", k, e.k);
      end else begin
        check("an", 16'(an), 16'(e.an));
        check("seg", 16'(seg), 16'(e.seg));
        check("dp", 16'(dp), 16'(e.dp));
      end
    end
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      check("rst_an", 16'(an), 16'hF);
      check("rst_seg", 16'(seg), 16'h7F);
      check("rst_dp", 16'(dp), 16'h1);
    end
    rst = 1'b0;
    k   = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout edge=%0d", k);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[9];
    logic [27:0] prev_segs;
    logic        prev_blz;
    int          f, r, r2, er;

    vecs[0] = '{16'h3A5F, 1'b0, {7'b0110000, 7'b0001000, 7'b0010010, 7'b0001110}};
    vecs[1] = '{16'h0070, 1'b1, {7'h7F, 7'h7F, 7'b1111000, 7'b1000000}};
    vecs[2] = '{16'h0070, 1'b0, {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000}};
    vecs[3] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}};
    vecs[4] = '{16'h1234, 1'b1, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[5] = '{16'h0B8D, 1'b1, {7'h7F, 7'b0000011, 7'b0000000, 7'b0100001}};
    vecs[6] = '{16'hEC96, 1'b0, {7'b0000110, 7'b1000110, 7'b0010000, 7'b0000010}};
    vecs[7] = '{16'h0007, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'b1111000}};
    vecs[8] = '{16'h1000, 1'b1, {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}};

    rst      = 1'b1;
    din      = '0;
    cout_in  = '0;
    blank_lz = 1'b0;
    clear_windows();

    // Reset values, then scan order over 20 edges.
    reset_cycles(2);
    push_range(0, 19, ZERO);
    while (k < 19) step();

    // Decode, snapshot and blanking: new din lands mid-frame; old snapshot shows until the
    // next frame start (checked only when blank_lz is unchanged, since blanking is live).
    prev_segs = ZERO;
    prev_blz  = 1'b0;
    for (int v = 0; v < 9; v++) begin
      while (k % FL != 5) step();
      din      = vecs[v].din;
      blank_lz = vecs[v].blz;
      f        = next_frame(k);
      if (vecs[v].blz == prev_blz) push_range(k + 1, f, prev_segs);
      push_range(f + 1, f + FL, vecs[v].segs);
      while (k < f + FL) step();
      prev_segs = vecs[v].segs;
      prev_blz  = vecs[v].blz;
    end

    // Settle to an all-zero snapshot for the carry tests.
    din      = '0;
    blank_lz = 1'b0;
    repeat (2 * FL) step();

    // One-clock carry pulse on digit 1.
    while (k % FL != 1) step();
    r         = k + 1;
    lit_lo[1] = r;
    lit_hi[1] = next_frame(r) + (HOLD - 1) * FL;
    push_range(r, lit_hi[1] + FL, ZERO);
    cout_in = 4'b0010;
    step();
    cout_in = 4'b0000;
    while (k < lit_hi[1] + FL) step();
    clear_windows();

    // Carry level held for 10 frames: one flash only.
    while (k % FL != 1) step();
    r         = k + 1;
    lit_lo[1] = r;
    lit_hi[1] = next_frame(r) + (HOLD - 1) * FL;
    push_range(r, r + 200, ZERO);
    cout_in = 4'b0010;
    repeat (10 * FL) step();
    cout_in = 4'b0000;
    while (k < r + 200) step();
    clear_windows();

    // Rise on digit 2 coincident with a frame start: the load wins.
    while (k % FL != FL - 2) step();
    r         = k + 1;
    lit_lo[2] = r;
    lit_hi[2] = next_frame(r) + (HOLD - 1) * FL;
    push_range(r, lit_hi[2] + FL, ZERO);
    cout_in = 4'b0100;
    step();
    cout_in = 4'b0000;
    while (k < lit_hi[2] + FL) step();
    clear_windows();

    // Second rise on digit 0 while its hold is 1 reloads it.
    while (k % FL != 5) step();
    r         = k + 1;
    r2        = r + 2 * FL;
    lit_lo[0] = r;
    lit_hi[0] = next_frame(r2) + (HOLD - 1) * FL;
    push_range(r, lit_hi[0] + FL, ZERO);
    cout_in = 4'b0001;
    step();
    cout_in = 4'b0000;
    while (k < r2 - 1) step();
    cout_in = 4'b0001;
    step();
    cout_in = 4'b0000;
    while (k < lit_hi[0] + FL) step();
    clear_windows();

    // Reset at idx 2 with hold[1] == 2 and a nonzero snapshot.
    din = 16'h3A5F;
    step();
    while (k % FL != FL - 1) step();
    while (k % FL != 1) step();
    r         = k + 1;
    f         = next_frame(r);
    er        = f + 10;
    lit_lo[1] = r;
    lit_hi[1] = f + (HOLD - 1) * FL;
    push_range(r, er - 1, vecs[0].segs);
    cout_in = 4'b0010;
    step();
    cout_in = 4'b0000;
    while (k < er - 1) step();
    reset_cycles(1);
    clear_windows();
    push_range(0, FL - 1, ZERO);
    push_range(FL, 2 * FL - 1, vecs[0].segs);
    while (k < 2 * FL - 1) step();

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL leftover_expectations got=%0d want=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_display.md
# seg7_scan_display

Time-multiplexed driver for four common-anode seven-segment digits, placed directly downstream of a cascade of four 4-bit up/down counter stages. It consumes each stage's 4-bit count and carry/borrow flag. Each stage's count is shown as a hex digit. A carry event on a stage stretches into a visible decimal-point flash on that stage's digit. Counts are snapshotted once per refresh frame so a digit never shows a torn value.

## Interface
- DIV, 50000: clock cycles per digit slot (scan tick period); legal 2..2^20
- HOLD, 3: frames a decimal point stays lit after a carry rising edge; legal 1..15
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- din  in  16  counter values; digit i = din[4i+3:4i], digit 0 least significant
- cout_in  in  4  carry/borrow flag of each counter stage, bit i for digit i
- blank_lz  in  1  1 = blank leading zeros (digit 0 never blanked)
- an  out  4  anode enables, active-low, one-hot-low while scanning
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

## Operation
- Prescaler pre counts 0..DIV-1 and wraps. tick = (pre == DIV-1).
- Scan index idx (2 bits) increments on tick and wraps 3 -> 0. frame_start = tick && idx == 3.
- Snapshot register snap[15:0] loads din on frame_start only. Between frame starts, din changes are invisible.
- Carry stretch, per digit i:
  - cout_d[i] registers cout_in[i] every clk; rise[i] = cout_in[i] & ~cout_d[i].
  - 4-bit hold[i] loads HOLD on rise[i].
  - Otherwise hold[i] decrements on frame_start if nonzero, saturating at 0.
  - If rise[i] and frame_start occur together, the load wins.
  - A level held high produces one rise only.
- Blanking: digit i (i = 1..3) is blank when blank_lz = 1 and snap nibbles i..3 are all zero. A blank digit drives seg = 7'h7F. dp still follows hold.
- Output registers, updated every clk from the current idx, snap, and hold:
  - an = ~(1 << idx)
  - seg = hex decode of snap nibble idx, or blank
  - dp = ~(hold[idx] != 0)
- Hex decode (active-low, g..a):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110

## Timing
- Reset (sampled rst = 1 at an edge):
  - pre = 0, idx = 0, snap = 0, hold = 0, cout_d = 0
  - an = 4'b1111, seg = 7'h7F, dp = 1
- First edge after rst falls: an = 4'b1110 and seg = 1000000 (digit 0 showing snapshot 0).
- Outputs lag idx/snap/hold by exactly one clk.
- Each digit is driven for DIV cycles. One frame is 4*DIV cycles.
- New din is visible at most 4*DIV+1 cycles after it is applied, and always starting with digit 0 of the next frame.
- A carry rise at edge k sets hold at edge k. The dp for that digit asserts during its next slot. It stays lit for HOLD frame starts, then clears.
- Reset mid-frame or mid-hold: everything returns to reset values at that edge. No partial frame or dp flash survives.
- rst has priority over tick, frame_start, and rise.
- an never has more than one bit low. an transitions only on the edge after a tick.

## Test plan
All scenarios use DIV = 4.
1. Reset and scan order: hold rst for 2 clk, release with din = 16'h0000.
   - During reset: an = 1111, seg = 7F, dp = 1.
   - Then an steps 1110 -> 1101 -> 1011 -> 0111 -> 1110, each value lasting 4 clk. seg = 1000000 throughout.
2. Decode and snapshot: din = 16'h3A5F applied mid-frame.
   - The current frame still shows 0000.
   - From the next frame: digit 0 = 0001110 (F), digit 1 = 0010010 (5), digit 2 = 0001000 (A), digit 3 = 0110000 (3).
3. Leading-zero blanking: din = 16'h0070.
   - blank_lz = 1: digits 3 and 2 show 7F, digit 1 shows 1111000, digit 0 shows 1000000.
   - blank_lz = 0: digits 3 and 2 show 1000000.
   - din = 0 with blank_lz = 1: only digit 0 shows 1000000.
4. Carry stretch, HOLD = 3: pulse cout_in[1] high for 1 clk.
   - dp = 0 during digit 1's slot for the following 3 frames, then 1.
   - Holding cout_in[1] high for 10 frames yields a single 3-frame flash.
5. Simultaneous events: rise[2] on the same edge as frame_start -> hold[2] = 3, not 2.
   - A second rise while hold[0] = 1 reloads it to 3.
6. Mid-operation reset: assert rst while idx = 2 and hold[1] = 2.
   - Next edge: an = 1111, dp = 1.
   - After release, the scan restarts at digit 0 with seg = 1000000 and no dp.
